// File: rtl/if_pkg.sv
// Shared constants and the fetch-entry record carried through the fetch queue.
package if_pkg;

   localparam int              NBITS     = 32;
   localparam logic [NBITS-1:0] TEXT_BASE = 32'h0040_0000;
   localparam logic [NBITS-1:0] RESET_PC  = 32'h0040_0000;
   localparam logic [NBITS-1:0] NOP       = '0;

   typedef struct packed {
      logic [NBITS-1:0] instr;
      logic [NBITS-1:0] pc;
      logic [NBITS-1:0] pc4;
      logic             fault;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with a flush input that beats push, and push-while-full when
// the head is popped in the same cycle. Head data is read straight from storage.
module fetch_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     valid_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   // Handshake: the head transfers when valid_o & pop_i; pop_i without valid_o is ignored.
   assign valid_o = (count_q != '0);
   assign do_pop  = pop_i & valid_o;
   assign do_push = push_i & ~clear_i & ((count_q != CW'(DEPTH)) | do_pop);

   always_comb begin
      rd_d    = rd_q;
      wr_d    = wr_q;
      count_d = count_q;
      if (clear_i) begin
         rd_d    = wr_q;
         count_d = '0;
      end else begin
         if (do_push) wr_d = wr_q + PW'(1);
         if (do_pop)  rd_d = rd_q + PW'(1);
         if (do_push && !do_pop)      count_d = count_q + CW'(1);
         else if (do_pop && !do_push) count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
      end else begin
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         count_q <= count_d;
         if (do_push) mem_q[wr_q] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[rd_q];
   assign count_o = count_q;

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch: PC register, program-memory addressing with range/alignment
// fault tagging, and a decoupling queue toward decode with redirect flush.
module if_fetch_queue
   import if_pkg::fetch_entry_t;
   import if_pkg::NOP;
#(
   parameter int                NBITS        = if_pkg::NBITS,
   parameter int                MEMORY_DEPTH = 512,
   parameter logic [NBITS-1:0]  TEXT_BASE    = if_pkg::TEXT_BASE,
   parameter logic [NBITS-1:0]  RESET_PC     = if_pkg::RESET_PC,
   parameter int                QDEPTH       = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          redirect_valid,
   input  logic [NBITS-1:0]              redirect_addr,
   output logic [$clog2(MEMORY_DEPTH)-1:0] imem_addr,
   input  logic [NBITS-1:0]              imem_rdata,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [NBITS-1:0]              out_instr,
   output logic [NBITS-1:0]              out_pc,
   output logic [NBITS-1:0]              out_pc4,
   output logic                          out_fault,
   output logic [$clog2(QDEPTH):0]       q_count
);

   localparam int               AW        = $clog2(MEMORY_DEPTH);
   localparam int               CW        = $clog2(QDEPTH) + 1;
   localparam logic [NBITS-1:0] MEM_BYTES = NBITS'(MEMORY_DEPTH * 4);

   logic [NBITS-1:0] pc_q, pc_d, offset;
   logic             in_range, pop, push;
   fetch_entry_t     wr_entry, rd_entry;

   assign offset    = pc_q - TEXT_BASE;
   assign imem_addr = offset[AW+1:2];
   assign in_range  = (offset < MEM_BYTES) && (pc_q[1:0] == 2'b00);
   assign pop       = out_valid & out_ready;
   assign push      = ~redirect_valid & ((q_count < CW'(QDEPTH)) | pop);

   // Out-of-range fetches still enter the queue, as a tagged NOP.
   always_comb begin
      wr_entry.instr = in_range ? imem_rdata : NOP;
      wr_entry.pc    = pc_q;
      wr_entry.pc4   = pc_q + NBITS'(4);
      wr_entry.fault = ~in_range;
   end

   always_comb begin
      pc_d = pc_q;
      if (redirect_valid) pc_d = redirect_addr;
      else if (push)      pc_d = pc_q + NBITS'(4);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) pc_q <= RESET_PC;
      else        pc_q <= pc_d;
   end

   fetch_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (QDEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .clear_i (redirect_valid),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (wr_entry),
      .rdata_o (rd_entry),
      .valid_o (out_valid),
      .count_o (q_count)
   );

   assign out_instr = rd_entry.instr;
   assign out_pc    = rd_entry.pc;
   assign out_pc4   = rd_entry.pc4;
   assign out_fault = rd_entry.fault;

endmodule
